// File: rtl/nibble_pkg.sv
// Shared widths and the output-slot state encoding for the nibble deserializer.
package nibble_pkg;
  localparam int NIB_W = 4;
  localparam int CNT_W = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_t;
endpackage

// File: rtl/nibble_deser.sv
// Serial-to-nibble deserializer with a one-entry output slot.
// The serial side never stalls: a nibble completing while the slot is full
// and not being drained is dropped and recorded in a sticky overflow flag.
module nibble_deser
  import nibble_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             bit_i,
  input  logic             bit_valid_i,
  output logic [NIB_W-1:0] nib_o,
  output logic             nib_valid_o,
  input  logic             nib_ready_i,
  output logic             ovf_o,
  input  logic             clr_ovf_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [NIB_W-1:0] sr;
  logic [NIB_W-1:0] sr_nxt;
  logic [NIB_W-1:0] nib;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             complete;
  logic             load;
  logic             drop;
  slot_t            state;
  slot_t            state_nxt;

  // Shifted value including the incoming bit; on completion this is the nibble
  always_comb begin
    sr_nxt = MSB_FIRST ? {sr[NIB_W-2:0], bit_i} : {bit_i, sr[NIB_W-1:1]};
  end

  // A nibble completes on the accepted bit that wraps the counter
  always_comb begin
    complete = bit_valid_i && (cnt == '1);
  end

  // Shift register: accepts every valid bit, holds across gaps
  always_ff @(posedge clk_i) begin
    if (rst_i)            sr <= '0;
    else if (bit_valid_i) sr <= sr_nxt;
  end

  // Bit counter toward the current nibble, wraps naturally 3 -> 0
  always_ff @(posedge clk_i) begin
    if (rst_i)            cnt <= '0;
    else if (bit_valid_i) cnt <= cnt + 1'b1;
  end

  // Slot state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Slot next state: completion always leaves it full (load or drop),
  // a drain with no completion empties it
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (complete) state_nxt = FULL;
      FULL:    if (nib_ready_i && !complete) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Slot outputs: load when the slot is free or being drained this cycle,
  // otherwise a completion is dropped
  always_comb begin
    nib_valid_o = (state == FULL);
    load        = complete && ((state == EMPTY) || nib_ready_i);
    drop        = complete && (state == FULL) && !nib_ready_i;
  end

  // Output nibble register; held while the slot waits on the consumer
  always_ff @(posedge clk_i) begin
    if (rst_i)     nib <= '0;
    else if (load) nib <= sr_nxt;
  end

  // Sticky overflow flag; a new drop beats a simultaneous clear
  always_ff @(posedge clk_i) begin
    if (rst_i)          ovf <= 1'b0;
    else if (drop)      ovf <= 1'b1;
    else if (clr_ovf_i) ovf <= 1'b0;
  end

  assign nib_o = nib;
  assign ovf_o = ovf;
  assign cnt_o = cnt;

endmodule

// File: tb/tb_nibble_deser.sv
// Scoreboard bench for nibble_deser: one MSB-first and one LSB-first instance
// share the serial stream; expected nibbles are queued when their 4th bit is
// driven and popped whenever the consumer takes one.
module tb_nibble_deser;
  logic       clk = 1'b0;
  logic       rst, bit_in, bit_vld, rdy, clr;
  logic [3:0] nib_m, nib_l;
  logic       vld_m, vld_l, ovf_m, ovf_l;
  logic [1:0] cnt_m, cnt_l;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] q_m[$];
  logic [3:0] q_l[$];

  always #5 clk = ~clk;

  nibble_deser #(.MSB_FIRST(1'b1)) u_msb (
    .clk_i(clk), .rst_i(rst), .bit_i(bit_in), .bit_valid_i(bit_vld),
    .nib_o(nib_m), .nib_valid_o(vld_m), .nib_ready_i(rdy),
    .ovf_o(ovf_m), .clr_ovf_i(clr), .cnt_o(cnt_m)
  );

  nibble_deser #(.MSB_FIRST(1'b0)) u_lsb (
    .clk_i(clk), .rst_i(rst), .bit_i(bit_in), .bit_valid_i(bit_vld),
    .nib_o(nib_l), .nib_valid_o(vld_l), .nib_ready_i(rdy),
    .ovf_o(ovf_l), .clr_ovf_i(clr), .cnt_o(cnt_l)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  // Consumer side: every handshake must match the head of the queue
  always @(negedge clk) begin
    if (!rst && vld_m && rdy) begin
      if (q_m.size() == 0) chk("sb_m_underflow", q_m.size(), 1);
      else                 chk("sb_m", nib_m, q_m.pop_front());
    end
    if (!rst && vld_l && rdy) begin
      if (q_l.size() == 0) chk("sb_l_underflow", q_l.size(), 1);
      else                 chk("sb_l", nib_l, q_l.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit_vld = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_bit(input logic b);
    bit_in  = b;
    bit_vld = 1'b1;
    step();
    bit_vld = 1'b0;
  endtask

  // Drive v MSB first; queue it (and its LSB-first image) if it will be kept
  task automatic send_nib(input logic [3:0] v, input bit keep);
    for (int i = 3; i >= 0; i--) begin
      if (i == 0 && keep) begin
        q_m.push_back(v);
        q_l.push_back(rev4(v));
      end
      bit_in  = v[i];
      bit_vld = 1'b1;
      step();
    end
    bit_vld = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bit_in = 1'b0; bit_vld = 1'b0; rdy = 1'b0; clr = 1'b0;
    step(); step();
    chk("rst_nib",  nib_m, 4'h0);
    chk("rst_vld",  vld_m, 0);
    chk("rst_ovf",  ovf_m, 0);
    chk("rst_cnt",  cnt_m, 0);
    rst = 1'b0;
    step();

    // Basic nibble, ready high: valid for exactly one cycle
    rdy = 1'b1;
    send_nib(4'b0100, 1'b1);
    chk("basic_vld",   vld_m, 1);
    chk("basic_nib",   nib_m, 4'b0100);
    chk("basic_nib_l", nib_l, 4'b0010);
    step();
    chk("basic_vld_drop", vld_m, 0);

    // Stall: second nibble dropped, first held, overflow raised
    rdy = 1'b0;
    send_nib(4'b1000, 1'b1);
    send_nib(4'b1010, 1'b0);
    chk("stall_nib", nib_m, 4'b1000);
    chk("stall_vld", vld_m, 1);
    chk("stall_ovf", ovf_m, 1);
    idle(2);
    chk("ovf_sticky", ovf_m, 1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("ovf_clr", ovf_m, 0);
    chk("hold_nib", nib_m, 4'b1000);

    // Drain and complete in the same cycle: slot reloads, no overflow
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    rdy = 1'b1;
    q_m.push_back(4'b1010);
    q_l.push_back(4'b0101);
    send_bit(1'b0);
    chk("swap_nib", nib_m, 4'b1010);
    chk("swap_vld", vld_m, 1);
    chk("swap_ovf", ovf_m, 0);
    step();
    chk("swap_empty", vld_m, 0);

    // Set and clear together: set wins
    rdy = 1'b0;
    send_nib(4'b0011, 1'b1);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    clr = 1'b1;
    send_bit(1'b1);
    clr = 1'b0;
    chk("set_wins", ovf_m, 1);
    chk("set_hold_nib", nib_m, 4'b0011);
    clr = 1'b1; step(); clr = 1'b0;
    rdy = 1'b1; step();
    chk("drained", vld_m, 0);

    // Partial nibble discarded by reset, gaps between bits
    send_bit(1'b1); chk("cnt_a", cnt_m, 1);
    send_bit(1'b1); chk("cnt_b", cnt_m, 2);
    rst = 1'b1; step(); rst = 1'b0;
    chk("cnt_rst", cnt_m, 0);
    send_bit(1'b0); chk("cnt_c", cnt_m, 1);
    idle(2);        chk("cnt_gap", cnt_m, 1);
    send_bit(1'b1); chk("cnt_d", cnt_m, 2);
    idle(2);
    send_bit(1'b0); chk("cnt_e", cnt_m, 3);
    idle(2);
    q_m.push_back(4'b0100);
    q_l.push_back(4'b0010);
    send_bit(1'b0);
    chk("cnt_wrap", cnt_m, 0);
    chk("gap_nib",  nib_m, 4'b0100);
    chk("gap_vld",  vld_m, 1);
    step();

    // LSB-first ordering
    send_nib(4'b0001, 1'b1);
    chk("lsb_nib", nib_l, 4'b1000);
    step();

    // Reset while full: pending nibble gone, no overflow
    rdy = 1'b0;
    send_nib(4'b0110, 1'b0);
    chk("full_pre_rst", vld_m, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("full_rst_vld", vld_m, 0);
    chk("full_rst_ovf", ovf_m, 0);
    chk("full_rst_nib", nib_m, 4'h0);
    rdy = 1'b1;
    step();

    // All 16 values back-to-back
    for (int v = 0; v < 16; v++) send_nib(4'(v), 1'b1);
    idle(3);
    chk("stream_ovf",   ovf_m, 0);
    chk("stream_ovf_l", ovf_l, 0);
    chk("sb_m_left", q_m.size(), 0);
    chk("sb_l_left", q_l.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
